// File: rtl/profile_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : profile_snapshot_ctrl
//  Description : Takes an atomic snapshot of four hardware profiling counters
//                through a custom-instruction handshake. One accepted trigger
//                runs this op sequence: freeze all counters, read counters 0..3
//                into local snapshot registers, then resume with a
//                per-snapshot enable mask and an optional clear. A watchdog
//                abandons the sequence when an op waits too long for ciDone.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    customId       ciN value driven on every issued op
//    timeoutCycles  max cycles ciStart is held without ciDone (<= 31)
//  Ports
//    clock          rising-edge system clock
//    reset          asynchronous, active-low reset
//    trigger        snapshot request, level-sampled while idle
//    clearOnSnap    clear all four counters on resume (sampled at accept)
//    enableMask     counters to re-enable on resume (sampled at accept)
//    ciStart        custom-instruction start, held until ciDone
//    ciN            custom-instruction id (0 when no op is active)
//    ciValueA       counter select, bits [1:0] used
//    ciValueB       control word: [3:0] enable, [7:4] disable, [11:8] reset
//    ciDone         op complete from the profiling unit
//    ciResult       counter value returned by a read op
//    busy           a snapshot sequence is in progress
//    snapValid      all four snapshot registers hold one complete snapshot
//    timeoutErr     sticky until next accept; last sequence timed out
//    rdSel          snapshot register select
//    rdData         snapshot register rdSel (combinational)
// ============================================================================
module profile_snapshot_ctrl #(
    parameter logic [7:0] customId      = 8'd8,
    parameter int         timeoutCycles = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic        clearOnSnap,
    input  logic [3:0]  enableMask,
    output logic        ciStart,
    output logic [7:0]  ciN,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        busy,
    output logic        snapValid,
    output logic        timeoutErr,
    input  logic [1:0]  rdSel,
    output logic [31:0] rdData
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_READ0  = 3'd2,
        ST_READ1  = 3'd3,
        ST_READ2  = 3'd4,
        ST_READ3  = 3'd5,
        ST_RESUME = 3'd6,
        ST_GAP    = 3'd7
    } state_t;

    // Control word that disables all four counters.
    localparam logic [11:0] C_CTRL_FREEZE = 12'h0F0;
    localparam logic [4:0]  C_WAIT_LIMIT  = 5'(timeoutCycles);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,       state_d;
    state_t      ret_state_q,   ret_state_d;    // op to issue after GAP
    logic        busy_q,        busy_d;
    logic        snap_valid_q,  snap_valid_d;
    logic        timeout_err_q, timeout_err_d;
    logic [4:0]  wait_q,        wait_d;
    logic [11:0] resume_ctrl_q, resume_ctrl_d;  // resume word, fixed at accept
    logic [31:0] snap_q [4];
    logic [31:0] snap_d [4];

    // Op outputs are registered; they are derived from the next state so
    // that they line up exactly with the state they belong to.
    logic        ci_start_q,    ci_start_d;
    logic [7:0]  ci_n_q,        ci_n_d;
    logic [1:0]  ci_sel_q,      ci_sel_d;
    logic [11:0] ci_ctrl_q,     ci_ctrl_d;

    logic [4:0]  w_wait_inc;

    assign w_wait_inc = wait_q + 5'd1;

    function automatic state_t next_op(input state_t s);
        state_t n;
        case (s)
            ST_FREEZE: n = ST_READ0;
            ST_READ0:  n = ST_READ1;
            ST_READ1:  n = ST_READ2;
            ST_READ2:  n = ST_READ3;
            default:   n = ST_RESUME;
        endcase
        return n;
    endfunction

    function automatic logic is_op(input state_t s);
        return (s != ST_IDLE) && (s != ST_GAP);
    endfunction

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        busy_d        = busy_q;
        snap_valid_d  = snap_valid_q;
        timeout_err_d = timeout_err_q;
        wait_d        = wait_q;
        resume_ctrl_d = resume_ctrl_q;
        for (int i = 0; i < 4; i++) begin
            snap_d[i] = snap_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d       = ST_FREEZE;
                    busy_d        = 1'b1;
                    snap_valid_d  = 1'b0;
                    timeout_err_d = 1'b0;
                    wait_d        = 5'd0;
                    resume_ctrl_d = {(clearOnSnap ? 4'hF : 4'h0), 4'h0, enableMask};
                end
            end

            ST_GAP: begin
                state_d = ret_state_q;
                wait_d  = 5'd0;
            end

            // All op states: hold the op until ciDone or the watchdog fires.
            default: begin
                if (ciDone) begin
                    wait_d = 5'd0;
                    case (state_q)
                        ST_READ0: snap_d[0] = ciResult;
                        ST_READ1: snap_d[1] = ciResult;
                        ST_READ2: snap_d[2] = ciResult;
                        ST_READ3: snap_d[3] = ciResult;
                        default:  ;
                    endcase
                    if (state_q == ST_RESUME) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        snap_valid_d = 1'b1;
                    end else begin
                        state_d     = ST_GAP;
                        ret_state_d = next_op(state_q);
                    end
                end else if (w_wait_inc == C_WAIT_LIMIT) begin
                    // Abandon without resuming: counters stay frozen and the
                    // registers captured so far keep their new values.
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    snap_valid_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    wait_d        = 5'd0;
                end else begin
                    wait_d = w_wait_inc;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Op output decode for the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        ci_start_d = 1'b0;
        ci_n_d     = 8'd0;
        ci_sel_d   = 2'd0;
        ci_ctrl_d  = 12'd0;

        if (is_op(state_d)) begin
            ci_start_d = 1'b1;
            ci_n_d     = customId;
        end

        case (state_d)
            ST_FREEZE: ci_ctrl_d = C_CTRL_FREEZE;
            ST_READ0:  ci_sel_d  = 2'd0;
            ST_READ1:  ci_sel_d  = 2'd1;
            ST_READ2:  ci_sel_d  = 2'd2;
            ST_READ3:  ci_sel_d  = 2'd3;
            ST_RESUME: ci_ctrl_d = resume_ctrl_d;
            default:   ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ret_state_q   <= ST_IDLE;
            busy_q        <= 1'b0;
            snap_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_q        <= 5'd0;
            resume_ctrl_q <= 12'd0;
            ci_start_q    <= 1'b0;
            ci_n_q        <= 8'd0;
            ci_sel_q      <= 2'd0;
            ci_ctrl_q     <= 12'd0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            busy_q        <= busy_d;
            snap_valid_q  <= snap_valid_d;
            timeout_err_q <= timeout_err_d;
            wait_q        <= wait_d;
            resume_ctrl_q <= resume_ctrl_d;
            ci_start_q    <= ci_start_d;
            ci_n_q        <= ci_n_d;
            ci_sel_q      <= ci_sel_d;
            ci_ctrl_q     <= ci_ctrl_d;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ciStart    = ci_start_q;
    assign ciN        = ci_n_q;
    assign ciValueA   = {30'd0, ci_sel_q};
    assign ciValueB   = {20'd0, ci_ctrl_q};
    assign busy       = busy_q;
    assign snapValid  = snap_valid_q;
    assign timeoutErr = timeout_err_q;
    assign rdData     = snap_q[rdSel];

endmodule
`default_nettype wire
